recon_neighbour_fetch: RTL and testbench
========================================

Name: recon_neighbour_fetch

Overview:
Read-side companion to the reconstructed-frame store in the IntraPred path. Given a macroblock coordinate, it fetches that MB's prediction neighbours from the reconstructed frame memory: corner, top row and left column. It substitutes 128 for pixels outside the frame and presents the set to the intra predictor with a valid/ready handshake. It owns one synchronous read port of the frame memory.

Parameters:
WIDTH, 1280, frame width in pixels
LENGTH, 720, frame height in pixels
MB_SIZE_L, 8, MB rows (left-column length)
MB_SIZE_W, 8, MB columns (top-row length)
ADDR_W, 20, frame-memory address width (ceil log2 of WIDTH*LENGTH)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE
mbnumber  in  32  [31:16] top pixel row of MB, [15:0] left pixel col of MB
busy  out  1  high from the cycle after an accepted start until the output handshake completes
mem_rd_en  out  1  read strobe
mem_addr  out  ADDR_W  pixel address = row*WIDTH + col
mem_rd_data  in  8  read data, valid exactly 1 cycle after mem_rd_en
out_valid  out  1  neighbour set valid
out_ready  in  1  consumer accepts
corner_pix  out  8  pixel (row-1, col-1)
top_pix  out  8 x MB_SIZE_W unpacked  pixels (row-1, col+j)
left_pix  out  8 x MB_SIZE_L unpacked  pixels (row+i, col-1)
top_avail  out  1  row != 0
left_avail  out  1  col != 0

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, mem_rd_en, out_valid = 0; mem_addr = 0; all pixel outputs = 0; avail flags = 0.
- FSM: IDLE -> FETCH on start, latching row/col and the avail flags. FETCH -> DRAIN after the last read is issued. DRAIN -> OUTPUT after the last data is captured. OUTPUT -> IDLE when out_valid && out_ready.
- Read order: corner (only if both avail), top j=0..W-1 (if top_avail), left i=0..L-1 (if left_avail). One read per cycle, no bubbles.
- Unavailable pixels are never read. They are loaded with 8'd128 on the start cycle.
- Timing: start accepted at edge 0. Reads are issued in cycles 1..N, where N = number of available reads. Data is captured one edge after each read. out_valid rises at edge N+2. With N = 0, out_valid rises at edge 2 and mem_rd_en is never asserted.
- Address arithmetic: 32-bit unsigned internally, truncated to ADDR_W. Row/col are trusted to be MB-aligned and within the frame; no range check.
- out_valid and all pixel outputs stay stable while out_valid && !out_ready.
- start while busy is ignored and has no effect.
- Handshake completes on the same edge that start is seen: that start is ignored. A new start is accepted only in IDLE, i.e. one cycle after completion.
- Reset mid-fetch: immediate return to IDLE. Any in-flight read data is discarded.

Optional Feature:
Macro RECON_TOP_RIGHT_EN. When defined:
- Adds output top_right_pix (8 x MB_SIZE_W) and output top_right_avail = top_avail && (col + 2*MB_SIZE_W <= WIDTH).
- When available, top-right pixels (row-1, col+W+j) are read immediately after the top row, before the left column.
- When unavailable but top_avail, every top-right pixel equals top_pix[W-1], with no extra reads.
- When top is also unavailable, all top-right pixels are 128.
When undefined, the port and logic are absent and timing is as above.

Decomposition:
- Package idaten_intra_pkg holds:
  - UNAVAIL_PIX = 8'd128
  - typedef pix_t (logic [7:0])
  - typedef mb_coord_t (struct of 16-bit row, 16-bit col)
  - enum fetch_state_t {IDLE, FETCH, DRAIN, OUTPUT}
- One sub-module, recon_addr_gen: given latched row/col and a read index, produces mem_addr and the destination slot. It is purely combinational, and the FSM stays in the top module.

Test Plan:
- Memory preloaded with mem[a] = a[7:0]; WIDTH=1280, 8x8; start with row=8, col=16.
  -> corner = 0x0F; top = 0x10..0x17; left all 0x0F; 17 reads at addresses 8975, 8976..8983, 10255 + i*1280; out_valid at edge 19.
- row=0, col=0 -> no mem_rd_en; all outputs 128; both avail flags 0; out_valid at edge 2.
- row=0, col=8 -> 8 left reads only; corner and top = 128; top_avail = 0, left_avail = 1; out_valid at edge 10.
- out_ready held low 5 cycles after out_valid, with start pulsed meanwhile -> outputs stable; start ignored; busy stays high; returns to IDLE one edge after ready.
- reset asserted at edge 6 of a full fetch -> outputs zero asynchronously; a new start at row=8, col=8 afterwards completes correctly with no stale data.
- RECON_TOP_RIGHT_EN, row=8, col=1272 -> top_right_avail = 0; top_right_pix all equal top_pix[7]; read count unchanged at 17.

Source files
------------

// File: rtl/recon_neighbour_fetch_pkg.sv
// Shared types for the intra-prediction neighbour fetch path: pixel type,
// unavailable-pixel fill value, macroblock coordinate and FSM/slot encodings.
package idaten_intra_pkg;

    typedef logic [7:0] pix_t;

    localparam pix_t UNAVAIL_PIX = 8'd128;

    // Read-index width; covers corner + top + top-right + left for 8x8 MBs.
    localparam int IDX_W = 8;

    typedef struct packed {
        logic [15:0] row;
        logic [15:0] col;
    } mb_coord_t;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUTPUT} fetch_state_t;

    typedef enum logic [1:0] {SLOT_CORNER, SLOT_TOP, SLOT_TOP_RIGHT, SLOT_LEFT} slot_kind_t;

endpackage

// File: rtl/recon_neighbour_fetch_if.sv
// Frame-memory read port plus the neighbour-set handshake towards the intra predictor.
// Top-right signals exist only when RECON_TOP_RIGHT_EN is defined.
interface recon_neighbour_fetch_if #(
    parameter int ADDR_W    = 20,
    parameter int MB_SIZE_L = 8,
    parameter int MB_SIZE_W = 8
);
    import idaten_intra_pkg::*;

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    pix_t              mem_rd_data;

    logic              out_valid;
    logic              out_ready;
    pix_t              corner_pix;
    pix_t              top_pix  [MB_SIZE_W];
    pix_t              left_pix [MB_SIZE_L];
    logic              top_avail;
    logic              left_avail;
`ifdef RECON_TOP_RIGHT_EN
    pix_t              top_right_pix [MB_SIZE_W];
    logic              top_right_avail;
`endif

    modport master (
        output mem_rd_en, mem_addr,
        input  mem_rd_data,
        output out_valid,
        input  out_ready,
`ifdef RECON_TOP_RIGHT_EN
        output top_right_pix, top_right_avail,
`endif
        output corner_pix, top_pix, left_pix, top_avail, left_avail
    );

    modport slave (
        input  mem_rd_en, mem_addr,
        output mem_rd_data,
        input  out_valid,
        output out_ready,
`ifdef RECON_TOP_RIGHT_EN
        input  top_right_pix, top_right_avail,
`endif
        input  corner_pix, top_pix, left_pix, top_avail, left_avail
    );

endinterface

// File: rtl/recon_neighbour_fetch_addr_gen.sv
// Maps a read index to its frame address and capture slot, skipping unavailable groups.
// Order: corner, top row, top-right (RECON_TOP_RIGHT_EN), left column.
module recon_addr_gen
    import idaten_intra_pkg::*;
#(
    parameter int WIDTH     = 1280,
    parameter int MB_SIZE_W = 8,
    parameter int ADDR_W    = 20,
    parameter int SLOT_W    = 3
) (
    input  mb_coord_t         coord,
    input  logic              top_avail,
    input  logic              left_avail,
`ifdef RECON_TOP_RIGHT_EN
    input  logic              top_right_avail,
`endif
    input  logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] addr,
    output slot_kind_t        slot_kind,
    output logic [SLOT_W-1:0] slot_idx
);
    logic [31:0] row, col, k;
    logic        done;

    // NOTE: combinational logic uses blocking '=' so k can be peeled group by group in order.
    // NOTE: every output gets a default before any branch, otherwise a latch is inferred.
    always_comb begin
        row       = 32'(coord.row);
        col       = 32'(coord.col);
        k         = 32'(idx);
        done      = 1'b0;
        addr      = '0;
        slot_kind = SLOT_LEFT;
        slot_idx  = '0;
        if (top_avail && left_avail) begin
            if (k == 32'd0) begin
                addr      = ADDR_W'((row - 32'd1) * 32'(WIDTH) + col - 32'd1);
                slot_kind = SLOT_CORNER;
                done      = 1'b1;
            end else begin
                k = k - 32'd1;
            end
        end
        if (!done && top_avail) begin
            if (k < 32'(MB_SIZE_W)) begin
                addr      = ADDR_W'((row - 32'd1) * 32'(WIDTH) + col + k);
                slot_kind = SLOT_TOP;
                slot_idx  = SLOT_W'(k);
                done      = 1'b1;
            end else begin
                k = k - 32'(MB_SIZE_W);
            end
        end
`ifdef RECON_TOP_RIGHT_EN
        if (!done && top_right_avail) begin
            if (k < 32'(MB_SIZE_W)) begin
                addr      = ADDR_W'((row - 32'd1) * 32'(WIDTH) + col + 32'(MB_SIZE_W) + k);
                slot_kind = SLOT_TOP_RIGHT;
                slot_idx  = SLOT_W'(k);
                done      = 1'b1;
            end else begin
                k = k - 32'(MB_SIZE_W);
            end
        end
`endif
        if (!done) begin
            addr      = ADDR_W'((row + k) * 32'(WIDTH) + col - 32'd1);
            slot_kind = SLOT_LEFT;
            slot_idx  = SLOT_W'(k);
        end
    end

endmodule

// File: rtl/recon_neighbour_fetch.sv
// Fetches corner/top/left neighbours (plus top-right when RECON_TOP_RIGHT_EN is defined)
// of one macroblock from the reconstructed frame and hands the set to the intra predictor.
module recon_neighbour_fetch
    import idaten_intra_pkg::*;
#(
    parameter int WIDTH     = 1280,
    parameter int LENGTH    = 720,
    parameter int MB_SIZE_L = 8,
    parameter int MB_SIZE_W = 8,
    parameter int ADDR_W    = $clog2(WIDTH * LENGTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [31:0]            mbnumber,
    output logic                   busy,
    recon_neighbour_fetch_if.master bus
);
    localparam int SLOT_W = $clog2((MB_SIZE_W > MB_SIZE_L) ? MB_SIZE_W : MB_SIZE_L);

    fetch_state_t      state, state_nxt;
    mb_coord_t         req, coord;
    logic              top_av, left_av, req_top, req_left;
    logic [IDX_W-1:0]  idx, n_reads;
    logic              rd_en, cap_valid;
    slot_kind_t        gen_kind, cap_kind;
    logic [SLOT_W-1:0] gen_idx, cap_idx;
    logic [ADDR_W-1:0] gen_addr;
    pix_t              corner_q;
    pix_t              top_q  [MB_SIZE_W];
    pix_t              left_q [MB_SIZE_L];
`ifdef RECON_TOP_RIGHT_EN
    logic              tr_av, req_tr;
    pix_t              tr_q   [MB_SIZE_W];
`endif

    assign req      = mb_coord_t'(mbnumber);
    assign req_top  = (req.row != 16'd0);
    assign req_left = (req.col != 16'd0);
`ifdef RECON_TOP_RIGHT_EN
    assign req_tr   = req_top && ((32'(req.col) + 32'(2 * MB_SIZE_W)) <= 32'(WIDTH));
`endif

    recon_addr_gen #(
        .WIDTH     (WIDTH),
        .MB_SIZE_W (MB_SIZE_W),
        .ADDR_W    (ADDR_W),
        .SLOT_W    (SLOT_W)
    ) u_addr_gen (
        .coord           (coord),
        .top_avail       (top_av),
        .left_avail      (left_av),
`ifdef RECON_TOP_RIGHT_EN
        .top_right_avail (tr_av),
`endif
        .idx             (idx),
        .addr            (gen_addr),
        .slot_kind       (gen_kind),
        .slot_idx        (gen_idx)
    );

    always_comb begin
        n_reads = '0;
        if (top_av && left_av) n_reads = n_reads + IDX_W'(1);
        if (top_av)            n_reads = n_reads + IDX_W'(MB_SIZE_W);
`ifdef RECON_TOP_RIGHT_EN
        if (tr_av)             n_reads = n_reads + IDX_W'(MB_SIZE_W);
`endif
        if (left_av)           n_reads = n_reads + IDX_W'(MB_SIZE_L);
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // DRAIN waits out the capture of the final read before presenting the set.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = FETCH;
            FETCH: begin
                if (n_reads == '0) begin
                    state_nxt = DRAIN;
                end else begin
                    rd_en = 1'b1;
                    if (idx == n_reads - IDX_W'(1)) state_nxt = DRAIN;
                end
            end
            DRAIN:   if (!cap_valid) state_nxt = OUTPUT;
            OUTPUT:  if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the pixel arrays are reset because they drive outputs that must read zero in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coord     <= '0;
            top_av    <= 1'b0;
            left_av   <= 1'b0;
            idx       <= '0;
            cap_valid <= 1'b0;
            cap_kind  <= SLOT_CORNER;
            cap_idx   <= '0;
            corner_q  <= '0;
            for (int j = 0; j < MB_SIZE_W; j++) top_q[j]  <= '0;
            for (int i = 0; i < MB_SIZE_L; i++) left_q[i] <= '0;
`ifdef RECON_TOP_RIGHT_EN
            tr_av     <= 1'b0;
            for (int j = 0; j < MB_SIZE_W; j++) tr_q[j]   <= '0;
`endif
        end else begin
            cap_valid <= rd_en;
            cap_kind  <= gen_kind;
            cap_idx   <= gen_idx;
            if (rd_en) idx <= idx + IDX_W'(1);
            if (state == IDLE && start) begin
                coord    <= req;
                top_av   <= req_top;
                left_av  <= req_left;
                idx      <= '0;
                corner_q <= UNAVAIL_PIX;
                for (int j = 0; j < MB_SIZE_W; j++) top_q[j]  <= UNAVAIL_PIX;
                for (int i = 0; i < MB_SIZE_L; i++) left_q[i] <= UNAVAIL_PIX;
`ifdef RECON_TOP_RIGHT_EN
                tr_av    <= req_tr;
                for (int j = 0; j < MB_SIZE_W; j++) tr_q[j]   <= UNAVAIL_PIX;
`endif
            end else if (cap_valid) begin
                case (cap_kind)
                    SLOT_CORNER: corner_q <= bus.mem_rd_data;
                    SLOT_TOP: begin
                        top_q[cap_idx] <= bus.mem_rd_data;
`ifdef RECON_TOP_RIGHT_EN
                        // Top-right beyond the frame edge replicates the last top pixel.
                        if (!tr_av && cap_idx == SLOT_W'(MB_SIZE_W - 1))
                            for (int j = 0; j < MB_SIZE_W; j++) tr_q[j] <= bus.mem_rd_data;
`endif
                    end
`ifdef RECON_TOP_RIGHT_EN
                    SLOT_TOP_RIGHT: tr_q[cap_idx] <= bus.mem_rd_data;
`endif
                    SLOT_LEFT: left_q[cap_idx] <= bus.mem_rd_data;
                    default: ;
                endcase
            end
        end
    end

    assign busy           = (state != IDLE);
    assign bus.mem_rd_en  = rd_en;
    assign bus.mem_addr   = rd_en ? gen_addr : '0;
    assign bus.out_valid  = (state == OUTPUT);
    assign bus.corner_pix = corner_q;
    assign bus.top_pix    = top_q;
    assign bus.left_pix   = left_q;
    assign bus.top_avail  = top_av;
    assign bus.left_avail = left_av;
`ifdef RECON_TOP_RIGHT_EN
    assign bus.top_right_pix   = tr_q;
    assign bus.top_right_avail = tr_av;
`endif

endmodule

// File: tb/tb_recon_neighbour_fetch.sv
// Self-checking bench for recon_neighbour_fetch: frame-level reference model, directed
// corner cases, reset mid-fetch and randomized macroblocks (honours RECON_TOP_RIGHT_EN).
module tb_recon_neighbour_fetch;
    import idaten_intra_pkg::*;

    localparam int WIDTH  = 1280;
    localparam int LENGTH = 720;
    localparam int MB_L   = 8;
    localparam int MB_W   = 8;
    localparam int ADDR_W = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] mbnumber;
    logic        busy;

    recon_neighbour_fetch_if #(.ADDR_W(ADDR_W), .MB_SIZE_L(MB_L), .MB_SIZE_W(MB_W)) bus ();

    recon_neighbour_fetch #(
        .WIDTH(WIDTH), .LENGTH(LENGTH), .MB_SIZE_L(MB_L), .MB_SIZE_W(MB_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mbnumber(mbnumber), .busy(busy), .bus(bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] salt     = 8'h00;

    int exp_addr[$];
    int exp_corner;
    int exp_top  [MB_W];
    int exp_left [MB_L];
    int exp_tr   [MB_W];
    bit exp_tavail, exp_lavail, exp_travail;
    int seen_reads, seen_valid_edge, seen_first_addr;

    // Frame memory content: low address byte, optionally scrambled per transaction.
    function automatic logic [7:0] mem_pix(int unsigned a);
        return a[7:0] ^ salt;
    endfunction

    function automatic int pix_at(int r, int c);
        if (r < 0 || c < 0) return 128;
        return int'(mem_pix(r * WIDTH + c));
    endfunction

    // One-cycle-latency synchronous read port; garbage whenever not reading.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem_pix(32'(bus.mem_addr));
        else               bus.mem_rd_data <= 8'($urandom);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic build_model(input int row, input int col);
        exp_addr.delete();
        exp_tavail  = (row != 0);
        exp_lavail  = (col != 0);
        exp_travail = 1'b0;
        if (row > 0 && col > 0) exp_addr.push_back((row - 1) * WIDTH + col - 1);
        if (row > 0) for (int j = 0; j < MB_W; j++) exp_addr.push_back((row - 1) * WIDTH + col + j);
`ifdef RECON_TOP_RIGHT_EN
        exp_travail = (row > 0) && (col + 2 * MB_W <= WIDTH);
        if (exp_travail)
            for (int j = 0; j < MB_W; j++) exp_addr.push_back((row - 1) * WIDTH + col + MB_W + j);
`endif
        if (col > 0) for (int i = 0; i < MB_L; i++) exp_addr.push_back((row + i) * WIDTH + col - 1);
        exp_corner = pix_at(row - 1, col - 1);
        for (int j = 0; j < MB_W; j++) exp_top[j] = pix_at(row - 1, col + j);
        for (int i = 0; i < MB_L; i++) exp_left[i] = pix_at(row + i, col - 1);
        for (int j = 0; j < MB_W; j++) begin
            if (exp_travail)     exp_tr[j] = pix_at(row - 1, col + MB_W + j);
            else if (row > 0)    exp_tr[j] = exp_top[MB_W - 1];
            else                 exp_tr[j] = 128;
        end
    endtask

    task automatic check_outputs();
        check("corner_pix", 32'(bus.corner_pix), exp_corner);
        for (int j = 0; j < MB_W; j++) check($sformatf("top_pix[%0d]", j), 32'(bus.top_pix[j]), exp_top[j]);
        for (int i = 0; i < MB_L; i++) check($sformatf("left_pix[%0d]", i), 32'(bus.left_pix[i]), exp_left[i]);
        check("top_avail", 32'(bus.top_avail), 32'(exp_tavail));
        check("left_avail", 32'(bus.left_avail), 32'(exp_lavail));
`ifdef RECON_TOP_RIGHT_EN
        for (int j = 0; j < MB_W; j++)
            check($sformatf("top_right_pix[%0d]", j), 32'(bus.top_right_pix[j]), exp_tr[j]);
        check("top_right_avail", 32'(bus.top_right_avail), 32'(exp_travail));
`endif
    endtask

    task automatic check_reset_state();
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_rd_en", 32'(bus.mem_rd_en), 0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_corner", 32'(bus.corner_pix), 0);
        for (int j = 0; j < MB_W; j++) check($sformatf("rst_top[%0d]", j), 32'(bus.top_pix[j]), 0);
        for (int i = 0; i < MB_L; i++) check($sformatf("rst_left[%0d]", i), 32'(bus.left_pix[i]), 0);
        check("rst_top_avail", 32'(bus.top_avail), 0);
        check("rst_left_avail", 32'(bus.left_avail), 0);
`ifdef RECON_TOP_RIGHT_EN
        for (int j = 0; j < MB_W; j++) check($sformatf("rst_tr[%0d]", j), 32'(bus.top_right_pix[j]), 0);
        check("rst_tr_avail", 32'(bus.top_right_avail), 0);
`endif
    endtask

    // Cycle c = number of rising edges since the accepting edge 0; sampled on the falling edge.
    task automatic run_txn(input int row, input int col, input int hold);
        int n;
        bit early;
        build_model(row, col);
        n               = exp_addr.size();
        early           = 1'($urandom_range(0, 1));
        seen_reads      = 0;
        seen_valid_edge = -1;
        seen_first_addr = -1;
        @(negedge clk);
        start         = 1'b1;
        mbnumber      = {16'(row), 16'(col)};
        bus.out_ready = (hold == 0) && early;
        @(negedge clk);
        for (int c = 1; c <= n + 3 + hold; c++) begin
            start    = 1'b0;
            mbnumber = $urandom;
            check("busy", 32'(busy), 1);
            check("mem_rd_en", 32'(bus.mem_rd_en), 32'(c <= n));
            if (bus.mem_rd_en) seen_reads++;
            if (c == 1 && bus.mem_rd_en) seen_first_addr = int'(bus.mem_addr);
            if (c <= n) check($sformatf("mem_addr[%0d]", c - 1), 32'(bus.mem_addr), exp_addr[c - 1]);
            check("out_valid", 32'(bus.out_valid), 32'(c >= n + 3));
            if (bus.out_valid && seen_valid_edge < 0) seen_valid_edge = c - 1;
            if (c >= n + 3) check_outputs();
            bus.out_ready = (c >= n + 3 + hold) || (hold == 0 && early);
            start = (c == n + 3 + hold) || (c == n + 4) || ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        check("done_busy", 32'(busy), 0);
        check("done_out_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        check("idle_mem_rd_en", 32'(bus.mem_rd_en), 0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        mbnumber      = '0;
        bus.out_ready = 1'b0;
        #2 reset = 1'b0;
        #10 check_reset_state();
        @(negedge clk);
        reset = 1'b1;

        // Fully interior MB: 17 reads, valid at edge 19.
        run_txn(8, 16, 0);
        check("pin_reads_8_16", seen_reads, 17);
        check("pin_valid_edge_8_16", seen_valid_edge, 19);
        check("pin_first_addr", seen_first_addr, 8975);
        check("pin_corner", 32'(bus.corner_pix), 32'h0F);
        check("pin_top0", 32'(bus.top_pix[0]), 32'h10);
        check("pin_top7", 32'(bus.top_pix[7]), 32'h17);
        check("pin_left7", 32'(bus.left_pix[7]), 32'h0F);

        // Frame origin: no reads at all.
        run_txn(0, 0, 0);
        check("pin_reads_0_0", seen_reads, 0);
        check("pin_valid_edge_0_0", seen_valid_edge, 2);
        check("pin_corner_0_0", 32'(bus.corner_pix), 128);
        check("pin_left0_0_0", 32'(bus.left_pix[0]), 128);

        // Top frame edge: left column only.
        run_txn(0, 8, 0);
        check("pin_reads_0_8", seen_reads, 8);
        check("pin_valid_edge_0_8", seen_valid_edge, 10);
        check("pin_top0_0_8", 32'(bus.top_pix[0]), 128);
        check("pin_left0_0_8", 32'(bus.left_pix[0]), 32'h07);
        check("pin_left_avail_0_8", 32'(bus.left_avail), 1);

        // Consumer stalls five cycles with start pulses arriving meanwhile.
        run_txn(8, 16, 5);
        check("pin_reads_hold", seen_reads, 17);

        // Reset just after edge 6 of a full fetch, then a clean fetch.
        @(negedge clk);
        start    = 1'b1;
        mbnumber = {16'd8, 16'd16};
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check_reset_state();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_txn(8, 8, 1);
        check("pin_reads_after_rst", seen_reads, 17);

`ifdef RECON_TOP_RIGHT_EN
        // Right frame edge: top-right replicates top_pix[7] (address 10239 -> 0xFF).
        run_txn(8, 1272, 0);
        check("pin_reads_tr_edge", seen_reads, 17);
        check("pin_tr_avail_edge", 32'(bus.top_right_avail), 0);
        check("pin_tr0_edge", 32'(bus.top_right_pix[0]), 32'hFF);
        check("pin_tr7_edge", 32'(bus.top_right_pix[7]), 32'hFF);
`endif

        for (int t = 0; t < 30; t++) begin
            int row;
            int col;
            case ($urandom_range(0, 3))
                0:       row = 0;
                1:       row = LENGTH - MB_L;
                default: row = MB_L * int'($urandom_range(0, LENGTH / MB_L - 1));
            endcase
            case ($urandom_range(0, 3))
                0:       col = 0;
                1:       col = WIDTH - MB_W;
                default: col = MB_W * int'($urandom_range(0, WIDTH / MB_W - 1));
            endcase
            salt = 8'($urandom);
            run_txn(row, col, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
